// File: rtl/demux14_stream_pkg.sv
// Shared types for the 1-to-4 stream demultiplexer.
`default_nettype none

package demux_pkg;

  localparam int LANES = 4;

  typedef logic [1:0] lane_sel_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

endpackage

`default_nettype wire

// File: rtl/demux14_stream_if.sv
// Producer/consumer bundle of the demultiplexer: one input stream, four output lanes.
`default_nettype none

interface demux14_stream_if
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] in_data;
  lane_sel_t        in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [LANES-1:0] out_valid;
  logic [LANES-1:0] out_ready;
  logic [CNT_W-1:0] out_cnt0;
  logic [CNT_W-1:0] out_cnt1;
  logic [CNT_W-1:0] out_cnt2;
  logic [CNT_W-1:0] out_cnt3;

  // Environment side: producer plus the four consumers.
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data0, out_data1, out_data2, out_data3,
    input  out_valid, out_cnt0, out_cnt1, out_cnt2, out_cnt3
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data0, out_data1, out_data2, out_data3,
    output out_valid, out_cnt0, out_cnt1, out_cnt2, out_cnt3
  );
endinterface

`default_nettype wire

// File: rtl/demux14_stream_lane.sv
// One output lane: single-entry data register, valid state and delivered-word counter.
`default_nettype none

module demux_lane
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_data,
  input  wire logic             ready,
  output logic      [WIDTH-1:0] data,
  output logic                  valid,
  output logic      [CNT_W-1:0] cnt
);

  lane_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deliver;

  assign deliver = (state_q == FULL) && ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (deliver) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (load) begin
      data_d = load_data;
    end
    unique case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL:  if (deliver && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data  = data_q;
  assign valid = (state_q == FULL);
  assign cnt   = cnt_q;

endmodule

`default_nettype wire

// File: rtl/demux14_stream.sv
// Registered 1-to-4 stream demultiplexer: routes each accepted word to lane in_sel.
`default_nettype none

module demux14_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input wire logic          clk,
  input wire logic          rst_n,
  demux14_stream_if.slave   bus
);

  logic [WIDTH-1:0] lane_data [LANES];
  logic [CNT_W-1:0] lane_cnt  [LANES];
  logic [LANES-1:0] lane_valid;
  logic             accept;

  // The selected lane can take a word if it is empty or emptying this cycle.
  assign bus.in_ready = !lane_valid[bus.in_sel] || bus.out_ready[bus.in_sel];
  assign accept       = bus.in_valid && bus.in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    demux_lane #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept && (bus.in_sel == lane_sel_t'(i))),
      .load_data (bus.in_data),
      .ready     (bus.out_ready[i]),
      .data      (lane_data[i]),
      .valid     (lane_valid[i]),
      .cnt       (lane_cnt[i])
    );
  end

  assign bus.out_valid = lane_valid;
  assign bus.out_data0 = lane_data[0];
  assign bus.out_data1 = lane_data[1];
  assign bus.out_data2 = lane_data[2];
  assign bus.out_data3 = lane_data[3];
  assign bus.out_cnt0  = lane_cnt[0];
  assign bus.out_cnt1  = lane_cnt[1];
  assign bus.out_cnt2  = lane_cnt[2];
  assign bus.out_cnt3  = lane_cnt[3];

endmodule

`default_nettype wire

// File: tb/tb_demux14_stream.sv
// Randomised and directed bench for demux14_stream against a queue-free lane model.
`default_nettype none

module tb_demux14_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;

  demux14_stream_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  demux14_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Model: per lane, whether a word is held, its value and the delivered count.
  bit      m_full [4];
  int      m_data [4];
  int      m_cnt  [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] dut_data(input int i);
    case (i)
      0:       return bus.out_data0;
      1:       return bus.out_data1;
      2:       return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] dut_cnt(input int i);
    case (i)
      0:       return bus.out_cnt0;
      1:       return bus.out_cnt1;
      2:       return bus.out_cnt2;
      default: return bus.out_cnt3;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      m_data[i] = 0;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic check_lanes(input string tag);
    logic [3:0] ev;
    for (int i = 0; i < 4; i++) begin
      ev[i] = m_full[i];
      check($sformatf("%s cnt%0d", tag, i), 32'(dut_cnt(i)), 32'(m_cnt[i] % 256));
      if (m_full[i])
        check($sformatf("%s data%0d", tag, i), 32'(dut_data(i)), 32'(m_data[i]));
    end
    check($sformatf("%s valid", tag), 32'(bus.out_valid), 32'(ev));
  endtask

  // One clock: check in_ready for the current inputs, advance model, check lanes.
  task automatic step(input string tag);
    int  sel;
    bit  rdy_exp;
    bit  acc;
    #1;
    sel     = int'(bus.in_sel);
    rdy_exp = !m_full[sel] || bus.out_ready[sel];
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'(rdy_exp));
    acc = bus.in_valid && rdy_exp;
    for (int i = 0; i < 4; i++) begin
      if (m_full[i] && bus.out_ready[i]) begin
        m_cnt[i]  = (m_cnt[i] + 1) % 256;
        m_full[i] = 1'b0;
      end
    end
    if (acc) begin
      m_full[sel] = 1'b1;
      m_data[sel] = int'(bus.in_data);
    end
    @(posedge clk);
    #1;
    check_lanes(tag);
  endtask

  task automatic drive(input bit v, input int sel, input int d, input logic [3:0] rdy);
    bus.in_valid  = v;
    bus.in_sel    = 2'(sel);
    bus.in_data   = 8'(d);
    bus.out_ready = rdy;
  endtask

  initial begin
    int start3;
    n_cmp = 0;
    n_bad = 0;
    drive(0, 0, 0, 4'b0000);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_lanes("init");

    // Reset mid-run with lanes 1 and 3 holding words.
    drive(1, 1, 8'h31, 4'b0000); step("fill1");
    drive(1, 3, 8'h33, 4'b0000); step("fill3");
    drive(0, 1, 0, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst valid", 32'(bus.out_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst data%0d", i), 32'(dut_data(i)), 32'h0);
      check($sformatf("rst cnt%0d", i), 32'(dut_cnt(i)), 32'h0);
    end
    check("rst in_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Walking one, then inverted, with all consumers ready.
    for (int pass = 0; pass < 2; pass++) begin
      for (int s = 0; s < 4; s++) begin
        int d;
        d = 8'h01 << s;
        if (pass == 1) d = (~d) & 8'hFF;
        drive(1, s, d, 4'b1111);
        step("walk");
        check("walk onehot", 32'(bus.out_valid), 32'(4'b0001 << s));
      end
      drive(0, 0, 0, 4'b1111);
      step("walk drain");
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("walk cnt%0d", i), 32'(dut_cnt(i)), 32'd2);

    // Back-pressure on lane 2, then retarget to lane 0.
    drive(1, 2, 8'hA5, 4'b1011); step("bp first");
    drive(1, 2, 8'h5A, 4'b1011);
    #1 check("bp blocked", 32'(bus.in_ready), 32'h0);
    repeat (5) begin
      step("bp hold");
      check("bp stable", 32'(bus.out_data2), 32'hA5);
    end
    drive(1, 0, 8'h5A, 4'b1011);
    #1 check("bp retarget", 32'(bus.in_ready), 32'h1);
    step("bp retarget");
    drive(0, 0, 0, 4'b1111); step("bp drain");

    // Simultaneous deliver and accept on lane 1.
    drive(1, 1, 8'h11, 4'b0000); step("sim load");
    drive(1, 1, 8'h22, 4'b0010); step("sim swap");
    check("sim data1", 32'(bus.out_data1), 32'h22);
    check("sim valid1", 32'(bus.out_valid[1]), 32'h1);
    drive(0, 0, 0, 4'b1111); step("sim drain");

    // Streaming 300 words to lane 3 without bubbles.
    start3 = int'(bus.out_cnt3);
    for (int k = 0; k < 300; k++) begin
      drive(1, 3, $urandom_range(0, 255), 4'b1111);
      step("stream");
    end
    drive(0, 0, 0, 4'b1111); step("stream drain");
    check("stream cnt3", 32'(bus.out_cnt3), 32'((start3 + 300) % 256));

    // Independence: fill all lanes, release only lanes 0 and 2.
    for (int s = 0; s < 4; s++) begin
      drive(1, s, 8'hC0 + s, 4'b0000);
      step("ind fill");
    end
    drive(0, 0, 0, 4'b0101); step("ind release");
    check("ind valid", 32'(bus.out_valid), 32'h0000000A);
    drive(0, 0, 0, 4'b1111); step("ind drain");

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3),
            $urandom_range(0, 255), 4'($urandom_range(0, 15)));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
